// File: rtl/pipelined_csel_adder.sv
// rtl/pipelined_csel_adder.sv - two-stage pipelined carry-select adder/subtractor with valid/ready streaming
module pipelined_csel_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NB = WIDTH / BLK;
    // Upper blocks (1..NB-1) carry both speculative results; keep at least one slot
    localparam int NH = (NB > 1) ? NB - 1 : 1;

    generate
        if ((WIDTH % BLK) != 0) begin : g_bad_width
            $error("pipelined_csel_adder: WIDTH must be a multiple of BLK");
        end
    endgenerate

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c_in;

    // Both stages move together; a stalled full output freezes the whole pipe
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Subtraction is a + ~b + 1, so cin only matters in add mode
    assign b_eff = sub ? ~b : b;
    assign c_in  = sub | cin;

    logic [BLK:0]         blk0_d;
    logic [NH-1:0][BLK:0] sum0_d;
    logic [NH-1:0][BLK:0] sum1_d;

    // Stage 1 precompute: block 0 uses the real carry-in, upper blocks both carry guesses
    always_comb begin
        blk0_d = {1'b0, a[BLK-1:0]} + {1'b0, b_eff[BLK-1:0]} + {{BLK{1'b0}}, c_in};
        sum0_d = '0;
        sum1_d = '0;
        for (int k = 1; k < NB; k++) begin
            sum0_d[k-1] = {1'b0, a[k*BLK +: BLK]} + {1'b0, b_eff[k*BLK +: BLK]};
            sum1_d[k-1] = {1'b0, a[k*BLK +: BLK]} + {1'b0, b_eff[k*BLK +: BLK]}
                          + {{BLK{1'b0}}, 1'b1};
        end
    end

    logic                 v1_q;
    logic [BLK:0]         blk0_q;
    logic [NH-1:0][BLK:0] sum0_q;
    logic [NH-1:0][BLK:0] sum1_q;
    logic                 amsb_q;
    logic                 bmsb_q;

    // Stage 1 register: loads a bubble when no beat is offered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            blk0_q <= '0;
            sum0_q <= '0;
            sum1_q <= '0;
            amsb_q <= 1'b0;
            bmsb_q <= 1'b0;
        end else if (advance) begin
            v1_q   <= in_valid;
            blk0_q <= blk0_d;
            sum0_q <= sum0_d;
            sum1_q <= sum1_d;
            amsb_q <= a[WIDTH-1];
            bmsb_q <= b_eff[WIDTH-1];
        end
    end

    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             ovf_d;

    // Stage 2 select chain: each block's chosen carry picks the next block's result
    always_comb begin
        res_d          = '0;
        res_d[BLK-1:0] = blk0_q[BLK-1:0];
        carry_d        = blk0_q[BLK];
        for (int k = 1; k < NB; k++) begin
            if (carry_d) begin
                res_d[k*BLK +: BLK] = sum1_q[k-1][BLK-1:0];
                carry_d             = sum1_q[k-1][BLK];
            end else begin
                res_d[k*BLK +: BLK] = sum0_q[k-1][BLK-1:0];
                carry_d             = sum0_q[k-1][BLK];
            end
        end
        ovf_d = (amsb_q == bmsb_q) && (res_d[WIDTH-1] != amsb_q);
    end

    // Stage 2 register: result data only changes when a real beat arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (advance) begin
            out_valid <= v1_q;
            if (v1_q) begin
                sum  <= res_d;
                cout <= carry_d;
                ovf  <= ovf_d;
            end
        end
    end

endmodule
